// File: rtl/bootdata_ioctl_bridge_pkg.sv
// Shared definitions for the boot-data to ioctl bridge: file-type codes,
// FSM state encoding and the menu-index mapping.
package bootdata_ioctl_bridge_pkg;

    localparam logic [2:0] FT_ROM = 3'b111;
    localparam logic [2:0] FT_P   = 3'b001;
    localparam logic [2:0] FT_O   = 3'b010;
    localparam logic [2:0] FT_COL = 3'b011;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_REQ = 3'd1;
    localparam logic [2:0] S_LATCH    = 3'd2;
    localparam logic [2:0] S_EMIT     = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_WAIT_REQ = S_WAIT_REQ,
        ST_LATCH    = S_LATCH,
        ST_EMIT     = S_EMIT,
        ST_GAP      = S_GAP,
        ST_FINISH   = S_FINISH
    } state_e;

    // ROM images load through menu slot 0; tape formats keep their type code.
    function automatic logic [15:0] map_index(input logic [2:0] ft);
        return (ft == FT_ROM) ? 16'd0 : {13'd0, ft};
    endfunction

endpackage

// File: rtl/bootdata_ioctl_bridge.sv
// Unpacks 32-bit boot-data words from the control module (req/ack handshake)
// into the byte-wide, rate-limited ioctl download stream, MSB first.
module bootdata_ioctl_bridge
    import bootdata_ioctl_bridge_pkg::*;
#(
    parameter int WR_GAP = 3,
    parameter int ADDR_W = 27
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       host_bootdata,
    input  logic              host_bootdata_req,
    output logic              host_bootdata_ack,
    input  logic              host_bootdata_download,
    input  logic [15:0]       host_bootdata_size,
    input  logic [2:0]        host_file_type,
    output logic              ioctl_download,
    output logic [15:0]       ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout
);

    localparam int GAP_W = $clog2(WR_GAP + 1);

    state_e            state_q, state_d;
    logic              dl_prev_q;
    logic              dl_q, dl_d;
    logic [15:0]       index_q, index_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              ack_q, ack_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       size_q, size_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              gap_ok;

    // gap_q counts idle cycles since the last emit slot and saturates, so the
    // spacing rule also holds across word boundaries (WAIT_REQ/LATCH).
    assign gap_ok = (gap_q >= GAP_W'(WR_GAP - 1));

    always_comb begin
        state_d = state_q;
        dl_d    = dl_q;
        index_d = index_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        ack_d   = ack_q & host_bootdata_req;
        shift_d = shift_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        gap_d   = (gap_q == GAP_W'(WR_GAP)) ? gap_q : gap_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (host_bootdata_download && !dl_prev_q) begin
                    dl_d    = 1'b1;
                    addr_d  = '0;
                    cnt_d   = '0;
                    index_d = map_index(host_file_type);
                    size_d  = host_bootdata_size;
                    gap_d   = GAP_W'(WR_GAP);
                    state_d = ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (host_bootdata_req && !ack_q) begin
                    shift_d = host_bootdata;
                    ack_d   = 1'b1;
                    lane_d  = 2'd0;
                    state_d = ST_LATCH;
                end else if (!host_bootdata_download) begin
                    state_d = ST_FINISH;
                end
            end
            ST_LATCH: begin
                if (gap_ok) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (cnt_q < size_q) begin
                    wr_d   = 1'b1;
                    dout_d = shift_q[31:24];
                    addr_d = ADDR_W'(cnt_q);
                    cnt_d  = cnt_q + 16'd1;
                end
                shift_d = {shift_q[23:0], 8'h00};
                lane_d  = lane_q + 2'd1;
                gap_d   = '0;
                if (lane_q == 2'd3 && !host_bootdata_download) state_d = ST_FINISH;
                else if (lane_q == 2'd3 && !host_bootdata_req) state_d = ST_WAIT_REQ;
                else state_d = ST_GAP;
            end
            ST_GAP: begin
                // lane wrapped to 0: the whole word is out, spacing is enforced in LATCH
                if (lane_q == 2'd0) state_d = host_bootdata_download ? ST_WAIT_REQ : ST_FINISH;
                else if (gap_ok) state_d = ST_EMIT;
            end
            ST_FINISH: begin
                dl_d = 1'b0;
                if (gap_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dl_prev_q <= 1'b0;
            dl_q      <= 1'b0;
            index_q   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            ack_q     <= 1'b0;
            lane_q    <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            dl_prev_q <= host_bootdata_download;
            dl_q      <= dl_d;
            index_q   <= index_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            ack_q     <= ack_d;
            lane_q    <= lane_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        shift_q <= shift_d;
        size_q  <= size_d;
    end

    assign host_bootdata_ack = ack_q;
    assign ioctl_download    = dl_q;
    assign ioctl_index       = index_q;
    assign ioctl_wr          = wr_q;
    assign ioctl_addr        = addr_q;
    assign ioctl_dout        = dout_q;

endmodule
